// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        StWaitIdle,
        StIdle,
        StData,
        StParity,
        StStop
    } rx_state_t;

    localparam logic        START_BIT  = 1'b0;
    localparam logic        IDLE_BIT   = 1'b1;
    localparam int unsigned FRAME_BITS = 11;

    // Parity bit that makes the total count of ones even.
    function automatic logic even_par(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, even parity, stop bit; one bit per clock.
// Parity comparison is enabled by defining SERIAL_RX_PARITY_CHECK_EN; otherwise parity_err is 0.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              start,
    input  logic              incoming,
    output logic [DATA_W-1:0] data_out,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned    CntW     = $clog2(DATA_W);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

    rx_state_t         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CntW-1:0]   cnt_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              ferr_q;
    logic              busy_q;
`ifdef SERIAL_RX_PARITY_CHECK_EN
    logic              par_q;
    logic              perr_q;
`endif

    always_ff @(posedge clk) begin
        if (start) begin
            state_q <= StWaitIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                // A line stuck low must return high before a start bit is accepted.
                StWaitIdle: begin
                    if (incoming == IDLE_BIT) state_q <= StIdle;
                end
                StIdle: begin
                    if (incoming == START_BIT) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StData;
                    end
                end
                StData: begin
                    shift_q <= {incoming, shift_q[DATA_W-1:1]};
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) state_q <= StParity;
                end
                StParity: begin
`ifdef SERIAL_RX_PARITY_CHECK_EN
                    par_q   <= incoming;
`endif
                    state_q <= StStop;
                end
                StStop: begin
                    busy_q <= 1'b0;
                    if (incoming == IDLE_BIT) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
`ifdef SERIAL_RX_PARITY_CHECK_EN
                        perr_q  <= even_par(shift_q) ^ par_q;
`endif
                        state_q <= StIdle;
                    end else begin
                        ferr_q  <= 1'b1;
                        state_q <= StWaitIdle;
                    end
                end
                default: state_q <= StWaitIdle;
            endcase
        end
    end

    assign data_out  = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
`ifdef SERIAL_RX_PARITY_CHECK_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial-to-parallel frame receiver: the far end of the parity-protected serial link whose transmitter shifts a byte out LSB first. It watches the single-bit line, detects the start bit, and shifts in 8 data bits and the parity bit. It checks the stop/idle bit, then presents the byte with a one-cycle valid strobe and parity/framing status. It sits on the same `clk` as the transmitter, one bit per clock, and feeds the downstream byte consumer.

## Interface
- `DATA_W`, 8: data bits per frame.
- `clk`  in  1  clock; all state updates on the rising edge. The transmitter drives the line on the falling edge, so bits are sampled mid-bit.
- `start`  in  1  synchronous, active-high reset.
- `incoming`  in  1  serial line; idle high.
- `data_out`  out  DATA_W  last received byte; holds until the next good frame.
- `rx_valid`  out  1  one-cycle strobe; `data_out` and `parity_err` are valid while it is high.
- `parity_err`  out  1  parity mismatch on the frame flagged by `rx_valid`.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled 0.
- `busy`  out  1  high while a frame is in progress (states DATA, PARITY, STOP).

## Operation
- Frame format on the line:
  - start bit 0;
  - d0..d7, LSB first;
  - parity bit p, where XOR(d7..d0, p) = 0 (even parity);
  - stop/idle bit 1.
- States:
  - WAIT_IDLE: stay until `incoming`=1, then go to IDLE. This is the reset state.
  - IDLE: `incoming`=0 is taken as the start bit; clear the bit counter and go to DATA.
  - DATA: shift `incoming` into the MSB of the shift register (right shift), so d0 ends at bit 0. Increment the 3-bit counter. After the DATA_W-th bit, go to PARITY.
  - PARITY: capture p, go to STOP.
  - STOP, `incoming`=1: load `data_out` and pulse `rx_valid`. Set `parity_err` = XOR(shift, p). Go to IDLE.
  - STOP, `incoming`=0: pulse `frame_err`. `data_out` is unchanged and there is no `rx_valid`. Go to WAIT_IDLE.
- Back-to-back frames: a 0 sampled in IDLE on the cycle right after a good stop bit starts the next frame. No extra idle cycle is required.
- Start-bit detection uses a single sample, with no oversampling or glitch filtering.
- `parity_err` is registered with `rx_valid` and holds its value until the next `rx_valid`.

## Timing
- Reset values: `data_out`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, state WAIT_IDLE.
- Let the start bit be sampled at edge k:
  - data bits are sampled at k+1..k+8;
  - parity at k+9;
  - stop at k+10.
- `rx_valid` or `frame_err` is high for the one cycle after edge k+10.
- Frame-to-frame minimum period: 11 clocks.
- `busy` rises after edge k and falls after edge k+10.
- `start` asserted mid-frame:
  - the frame is discarded and no strobe is issued;
  - outputs return to their reset values on the next edge;
  - the receiver must see a 1 before it re-arms, so a line held low through reset is not taken as a start bit.

## Configuration
- `SERIAL_RX_PARITY_CHECK_EN`:
  - Defined: parity is checked as above.
  - Undefined: the parity bit is still consumed (frame timing unchanged) but not compared, and `parity_err` is tied to 0.

## Structure
- Package `serial_frame_pkg`:
  - state enum `rx_state_t` (WAIT_IDLE, IDLE, DATA, PARITY, STOP);
  - constants `START_BIT`=1'b0, `IDLE_BIT`=1'b1, `FRAME_BITS`=11;
  - function `even_par(data)`.
- Single module, no sub-module. The shift register, bit counter and FSM are small enough to live inline.

## Test plan
- Reset, line idle, then frame for 0xA5: line 0,1,0,1,0,0,1,0,1,p=0,1. Expect `rx_valid` 1 cycle after the stop bit, `data_out`=0xA5, `parity_err`=0.
- Frame for 0x07 with p=1 -> `data_out`=0x07, `parity_err`=0. Same frame with p=0 -> `rx_valid` with `parity_err`=1. With the macro undefined -> `parity_err`=0.
- Frame for 0x3C with stop bit 0 -> `frame_err` pulse, no `rx_valid`, `data_out` keeps its previous value. Line held low for 5 cycles -> no new frame until the line returns to 1.
- Back-to-back 0x81 then 0x7E with no idle gap -> two `rx_valid` strobes 11 cycles apart with the correct bytes.
- `start` pulsed after d3 of 0xFF -> no strobe, outputs reset. A following 0x12 frame is received correctly.
- Line held low while `start` deasserts -> stays in WAIT_IDLE, `busy`=0, until `incoming`=1.
